inst_mem_slave: RTL and testbench

Read-only instruction memory acting as the bus responder for the instruction fetch master. It samples HADDR/HTRANS, inserts a configurable number of wait states, and returns instruction words on HRDATA with HREADY/HRESP. A side-band loader port writes the program image. It sits between the fetch stage and the on-chip instruction RAM.

---
 rtl/inst_mem_slave_pkg.sv | 15 +
 rtl/inst_mem_slave_array.sv | 39 +++
 rtl/inst_mem_slave.sv | 129 ++++++++++++
 tb/tb_inst_mem_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_slave_pkg.sv
// Shared bus-responder definitions for the fetch and data-memory slaves.
package inst_mem_slave_pkg;

    localparam logic [31:0] NOP_WORD      = 32'h0000_0013;
    localparam logic        HTRANS_IDLE   = 1'b0;
    localparam logic        HTRANS_ACTIVE = 1'b1;
    localparam int unsigned WAIT_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } bus_state_t;

endpackage

// File: rtl/inst_mem_slave_array.sv
// Instruction word storage: one write port, two combinational reads (idx, idx+1) with write-first bypass.
module imem_array #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata_lo_c,
    output logic [31:0]              rdata_hi_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] raddr_hi;

    // idx+1 wraps modulo DEPTH through natural AW-bit overflow
    assign raddr_hi = raddr + AW'(1);

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_lo_c = mem[raddr];
        rdata_hi_c = mem[raddr_hi];
        if (we && (waddr == raddr)) begin
            rdata_lo_c = wdata;
        end
        if (we && (waddr == raddr_hi)) begin
            rdata_hi_c = wdata;
        end
    end

endmodule

// File: rtl/inst_mem_slave.sv
// Read-only instruction memory bus responder with configurable wait states and a side-band loader.
module inst_mem_slave
    import inst_mem_slave_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter logic [31:0] NOP_WORD    = inst_mem_slave_pkg::NOP_WORD
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [63:0]              HADDR,
    input  logic                     HTRANS,
    output logic [63:0]              HRDATA,
    output logic                     HREADY,
    output logic                     HRESP,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);

    localparam int unsigned          AW       = $clog2(DEPTH);
    localparam logic [63:0]          SPAN     = 64'(DEPTH) * 64'd4;
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    bus_state_t              state, next_state;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic                    err_q, err_d;
    logic [63:0]             hrdata_d;
    logic                    hresp_d;
    logic                    hready_d;

    logic [63:0]             offset_c;
    logic [AW-1:0]           acc_idx_c;
    logic                    acc_err_c;
    logic                    accept_c;
    logic [AW-1:0]           rd_idx_c;
    logic                    rd_err_c;
    logic [31:0]             rd_lo_c, rd_hi_c;

    // Range check on the full 64-bit offset; truncation to an index happens only afterwards
    assign offset_c  = HADDR - BASE_ADDR;
    assign acc_err_c = (HADDR[1:0] != 2'b00) || (offset_c >= SPAN);
    assign acc_idx_c = offset_c[AW+1:2];
    assign accept_c  = (HTRANS == HTRANS_ACTIVE) && HREADY;

    // Zero-wait accesses read the live address; otherwise the captured one
    always_comb begin
        rd_idx_c = idx_q;
        rd_err_c = err_q;
        if (accept_c && (WAIT_STATES == 0)) begin
            rd_idx_c = acc_idx_c;
            rd_err_c = acc_err_c;
        end
    end

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .CLK        (CLK),
        .we         (load_en),
        .waddr      (load_addr),
        .wdata      (load_data),
        .raddr      (rd_idx_c),
        .rdata_lo_c (rd_lo_c),
        .rdata_hi_c (rd_hi_c)
    );

    always_comb begin
        next_state = state;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        hrdata_d   = HRDATA;
        hresp_d    = 1'b0;
        unique case (state)
            ST_IDLE, ST_DATA: begin
                next_state = ST_IDLE;
                if (accept_c) begin
                    idx_d = acc_idx_c;
                    err_d = acc_err_c;
                    if (WAIT_STATES == 0) begin
                        next_state = ST_DATA;
                    end else begin
                        next_state = ST_WAIT;
                        cnt_d      = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    next_state = ST_DATA;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            default: next_state = ST_IDLE;
        endcase
        // Data phase payload is captured on the edge that enters DATA
        if (next_state == ST_DATA) begin
            hresp_d  = rd_err_c;
            hrdata_d = rd_err_c ? {NOP_WORD, NOP_WORD} : {rd_hi_c, rd_lo_c};
        end
        hready_d = (next_state != ST_WAIT);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt_q  <= '0;
            idx_q  <= '0;
            err_q  <= 1'b0;
            HRDATA <= 64'h0;
            HREADY <= 1'b1;
            HRESP  <= 1'b0;
        end else begin
            state  <= next_state;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            err_q  <= err_d;
            HRDATA <= hrdata_d;
            HREADY <= hready_d;
            HRESP  <= hresp_d;
        end
    end

endmodule

// File: tb/tb_inst_mem_slave.sv
// Scoreboard bench for inst_mem_slave: three instances (1, 0 and 3 wait states) sharing clock, reset and loader.
module tb_inst_mem_slave;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam logic [63:0] ERR_D = 64'h00000013_00000013;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   haddr = 64'h0;
    logic          htrans [3];
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = 32'h0;
    logic [63:0]   hrdata [3];
    logic          hready [3];
    logic          hresp  [3];

    int checks = 0;
    int passes = 0;
    int pend [3] = '{0, 0, 0};
    logic [63:0] exp_data [$];
    logic        exp_resp [$];
    int          exp_dut  [$];

    always #5 CLK = ~CLK;

    inst_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(1), .BASE_ADDR(64'h0)) u_w1 (
        .CLK(CLK), .reset(reset), .HADDR(haddr), .HTRANS(htrans[0]),
        .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    inst_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(64'h0)) u_w0 (
        .CLK(CLK), .reset(reset), .HADDR(haddr), .HTRANS(htrans[1]),
        .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    inst_mem_slave #(.DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(64'h100)) u_w3 (
        .CLK(CLK), .reset(reset), .HADDR(haddr), .HTRANS(htrans[2]),
        .HRDATA(hrdata[2]), .HREADY(hready[2]), .HRESP(hresp[2]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Present an address phase to one instance and hold it until accepted
    task automatic issue(input int d, input logic [63:0] a, input logic [63:0] ed, input logic er);
        bit acc;
        int n;
        haddr     = a;
        htrans[d] = 1'b1;
        exp_data.push_back(ed);
        exp_resp.push_back(er);
        exp_dut.push_back(d);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = hready[d];
            tick();
            n++;
        end
        if (!acc) begin
            checks++;
            $display("FAIL accept_timeout dut%0d: got no accept expected accept", d);
        end
    endtask

    task automatic idle();
        foreach (htrans[i]) htrans[i] = 1'b0;
        tick();
    endtask

    // Monitor: a data phase is HREADY=1 while an accepted transfer is outstanding
    always @(negedge CLK) begin
        if (!reset) begin
            pend = '{0, 0, 0};
            exp_data.delete();
            exp_resp.delete();
            exp_dut.delete();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (pend[d] > 0 && hready[d]) begin
                    pend[d]--;
                    if (exp_data.size() == 0 || exp_dut[0] != d) begin
                        checks++;
                        $display("FAIL unexpected_data dut%0d: got %h expected none", d, hrdata[d]);
                    end else begin
                        chk($sformatf("dut%0d_hrdata", d), hrdata[d], exp_data[0]);
                        chk($sformatf("dut%0d_hresp", d), 64'(hresp[d]), 64'(exp_resp[0]));
                        void'(exp_data.pop_front());
                        void'(exp_resp.pop_front());
                        void'(exp_dut.pop_front());
                    end
                end
                if (htrans[d] && hready[d]) pend[d]++;
            end
        end
    end

    initial begin
        int n;
        foreach (htrans[i]) htrans[i] = 1'b0;
        #3 reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_hready%0d", d), 64'(hready[d]), 64'd1);
            chk($sformatf("reset_hresp%0d", d), 64'(hresp[d]), 64'd0);
            chk($sformatf("reset_hrdata%0d", d), hrdata[d], 64'h0);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();

        load(4'd0, 32'h00000093);
        load(4'd1, 32'h00100113);
        load(4'd2, 32'h00200193);
        load(4'd3, 32'h00300213);
        load(4'd15, 32'hDEADBEEF);

        // One wait state
        issue(0, 64'h0, 64'h00100113_00000093, 1'b0);
        chk("w1_wait_hready_low", 64'(hready[0]), 64'd0);
        idle();
        idle();

        // Zero wait states, back-to-back
        issue(1, 64'h0, 64'h00100113_00000093, 1'b0);
        chk("w0_hready_0", 64'(hready[1]), 64'd1);
        issue(1, 64'h4, 64'h00200193_00100113, 1'b0);
        chk("w0_hready_1", 64'(hready[1]), 64'd1);
        issue(1, 64'h8, 64'h00300213_00200193, 1'b0);
        chk("w0_hready_2", 64'(hready[1]), 64'd1);
        idle();
        idle();

        // Misaligned and just-past-end errors, pipelined
        issue(0, 64'h2, ERR_D, 1'b1);
        issue(0, 64'h40, ERR_D, 1'b1);
        idle();
        idle();
        idle();

        // Last word, idx+1 wraps to word 0
        issue(0, 64'h3C, 64'h00000093_DEADBEEF, 1'b0);
        idle();
        idle();
        idle();

        // Load into idx+1 on the DATA-entry edge
        load_en   = 1'b1;
        load_addr = 4'd1;
        load_data = 32'hCAFEF00D;
        issue(1, 64'h0, 64'hCAFEF00D_00000093, 1'b0);
        load_en   = 1'b0;
        idle();
        idle();

        // Non-zero base, three wait states, address below base
        issue(2, 64'h104, 64'h00200193_CAFEF00D, 1'b0);
        repeat (5) idle();
        issue(2, 64'h0, ERR_D, 1'b1);
        repeat (5) idle();

        // Reset during WAIT aborts the transfer
        issue(2, 64'h100, 64'h00100113_00000093, 1'b0);
        idle();
        reset = 1'b0;
        #1;
        chk("abort_hready", 64'(hready[2]), 64'd1);
        chk("abort_hresp", 64'(hresp[2]), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        repeat (6) tick();
        chk("post_abort_hready", 64'(hready[2]), 64'd1);
        chk("post_abort_hrdata", hrdata[2], 64'h0);
        issue(2, 64'h108, 64'h00300213_00200193, 1'b0);
        repeat (5) idle();

        n = 0;
        while (exp_data.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        while (exp_data.size() != 0) begin
            checks++;
            $display("FAIL missing_data dut%0d: got nothing expected %h", exp_dut[0], exp_data[0]);
            void'(exp_data.pop_front());
            void'(exp_resp.pop_front());
            void'(exp_dut.pop_front());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
